// File: rtl/cpu_pkg.sv
// Shared CPU/memory definitions: default bus widths and the read-return tag encoding.
package cpu_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE  = 2'd0;
    localparam tag_t TAG_LD    = 2'd1;
    localparam tag_t TAG_DATA  = 2'd2;
    localparam tag_t TAG_FETCH = 2'd3;
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/return bundle between the loader, CPU data and fetch ports, the arbiter and the memory.
interface mem_arbiter_if
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  f_req, f_addr,
        input  mem_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester/memory side
    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output f_req, f_addr,
        output mem_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_tag_pipe.sv
// MEM_LAT-deep shift register of read-return tags, aligned with the memory read latency.
module arb_tag_pipe
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic clear,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t tag_p [MEM_LAT];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < MEM_LAT; i++) tag_p[i] <= TAG_NONE;
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    assign tag_out = tag_p[MEM_LAT-1];
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for loader, CPU data and fetch ports, with fetch starvation
// promotion and tag-routed read return.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic         clk,
    input  logic         clear,
    mem_arbiter_if.slave bus
);
    logic [3:0]    starve_cnt;
    logic          promoted;
    logic          gnt_ld;
    logic          gnt_d;
    logic          gnt_f;
    tag_t          tag_in;
    tag_t          tag_out;
    logic [DW-1:0] ld_hold;
    logic [DW-1:0] d_hold;
    logic [DW-1:0] f_hold;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;

    assign promoted = (STARVE_LIMIT != 0) && (int'(starve_cnt) >= STARVE_LIMIT);

    // Grant decode: promoted fetch jumps ahead of the loader; clear masks every grant
    always_comb begin
        gnt_ld = 1'b0;
        gnt_d  = 1'b0;
        gnt_f  = 1'b0;
        if (!clear) begin
            if (promoted && bus.f_req) gnt_f  = 1'b1;
            else if (bus.ld_req)       gnt_ld = 1'b1;
            else if (bus.d_req)        gnt_d  = 1'b1;
            else if (bus.f_req)        gnt_f  = 1'b1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        tag_in    = TAG_NONE;
        if (gnt_ld) begin
            sel_we    = bus.ld_we;
            sel_addr  = bus.ld_addr;
            sel_wdata = bus.ld_wdata;
            tag_in    = bus.ld_we ? TAG_NONE : TAG_LD;
        end else if (gnt_d) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            tag_in    = bus.d_we ? TAG_NONE : TAG_DATA;
        end else if (gnt_f) begin
            sel_addr  = bus.f_addr;
            tag_in    = TAG_FETCH;
        end
    end

    assign bus.ld_gnt    = gnt_ld;
    assign bus.d_gnt     = gnt_d;
    assign bus.f_gnt     = gnt_f;
    assign bus.mem_en    = gnt_ld | gnt_d | gnt_f;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    always_ff @(posedge clk) begin
        if (clear) begin
            starve_cnt <= '0;
        end else if (bus.f_req && !gnt_f) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk     (clk),
        .clear   (clear),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Return stage: tag at the pipe output selects which port sees mem_rdata
    always_ff @(posedge clk) begin
        if (clear) begin
            ld_hold <= '0;
            d_hold  <= '0;
            f_hold  <= '0;
        end else begin
            if (tag_out == TAG_LD)    ld_hold <= bus.mem_rdata;
            if (tag_out == TAG_DATA)  d_hold  <= bus.mem_rdata;
            if (tag_out == TAG_FETCH) f_hold  <= bus.mem_rdata;
        end
    end

    assign bus.ld_rvalid = !clear && (tag_out == TAG_LD);
    assign bus.d_rvalid  = !clear && (tag_out == TAG_DATA);
    assign bus.f_rvalid  = !clear && (tag_out == TAG_FETCH);

    assign bus.ld_rdata = clear ? '0 : (bus.ld_rvalid ? bus.mem_rdata : ld_hold);
    assign bus.d_rdata  = clear ? '0 : (bus.d_rvalid  ? bus.mem_rdata : d_hold);
    assign bus.f_rdata  = clear ? '0 : (bus.f_rvalid  ? bus.mem_rdata : f_hold);
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 64K x 16 program/data memory between three requesters.
  - Loader port: fills the memory before or while the CPU is held.
  - CPU data port: loads and stores.
  - CPU instruction-fetch port.
- Issues at most one memory access per cycle.
- Routes read data back to the requester that issued the read.
- Guarantees fetch forward progress with a starvation counter.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (mem_rdata valid MEM_LAT cycles after issue); legal range 1..4.
- STARVE_LIMIT, 8, consecutive denied fetch cycles before fetch is promoted to top priority; 0 disables promotion.
- AW, 16, address width (word addressed).
- DW, 16, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- clear  in  1  reset, synchronous, active-high
- ld_req  in  1  loader access request
- ld_we  in  1  loader write enable
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader access issued this cycle
- d_req  in  1  CPU data request
- d_we  in  1  CPU data write enable
- d_addr  in  AW  CPU data address
- d_wdata  in  DW  CPU data write data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  data read result valid
- d_rdata  out  DW  data read result
- f_req  in  1  fetch request (read only)
- f_addr  in  AW  fetch address (pc)
- f_gnt  out  1  fetch issued this cycle
- f_rvalid  out  1  fetched instruction valid
- f_rdata  out  DW  fetched instruction
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- ld_rvalid  out  1  loader read result valid
- ld_rdata  out  DW  loader read result

Behaviour:
- Clock and reset: one clock, clk; reset is clear, synchronous, active-high.
- Grant, issue and handshake:
  - Grants are combinational from the current req inputs and registered state.
  - Granted port's addr/we/wdata are driven onto mem_* in the same cycle, with mem_en=1.
  - A requester holds req and its payload stable until it sees gnt high at a clock edge.
  - gnt is high for exactly one cycle per access; back-to-back grants to the same port are allowed.
  - The requester may present a new request in the cycle after gnt.
  - No req high: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Priority, normal: loader > data > fetch.
- Priority, promoted: when starve_cnt >= STARVE_LIMIT and STARVE_LIMIT != 0, fetch > loader > data.
- Starvation counter (starve_cnt, 4 bits, saturating):
  - Increments each cycle with f_req=1 and f_gnt=0.
  - Cleared to 0 on f_gnt or when f_req=0.
- Read return:
  - Each issue pushes a 2-bit tag (NONE/LD/DATA/FETCH) into a MEM_LAT-deep shift register.
  - Writes push NONE.
  - When the tag at the output is X, X_rvalid=1 for one cycle and X_rdata=mem_rdata.
  - rdata outputs hold their last value when rvalid=0.
- Read-after-write: a write issued in cycle N followed by a read of the same address in N+1 must return the new data. The memory guarantees write-first; the arbiter adds nothing.
- Reset (clear=1 at an edge):
  - Cleared: tag pipe to NONE, starve_cnt=0, all rvalid=0, all rdata=0.
  - Reads in flight at reset are dropped: no rvalid for them.
  - While clear=1 all gnt=0 and mem_en=0, regardless of req.
- Boundary conditions:
  - Addresses pass through unmodified, including 0xFFFF.
  - All three req high with promotion active: only f_gnt.
  - STARVE_LIMIT=0: fetch can be starved indefinitely; this is intended for loader-only boot.

Decomposition:
- Shared package cpu_pkg holds:
  - tag encoding constants TAG_NONE=0, TAG_LD=1, TAG_DATA=2, TAG_FETCH=3;
  - AW/DW defaults, shared with cpu.
- One sub-module: arb_tag_pipe, the parameterised MEM_LAT-deep tag shift register with synchronous clear.

Test Plan:
- Fetch only: f_req=1, f_addr=0x0000..0x0003 on consecutive grants, memory preloaded with 0xA000+addr → f_gnt every cycle; f_rvalid MEM_LAT cycles later with f_rdata=0xA000..0xA003 in order.
- Data write then fetch read, same address 0x0010, d_wdata=0x1234 → d_gnt first; next-cycle fetch returns 0x1234; d_rvalid never asserts.
- Contention, STARVE_LIMIT=8: d_req and f_req held high → 8 d_gnt, then f_gnt exactly once, then d_gnt resumes; starve_cnt back to 0.
- Loader vs data: ld_req and d_req together, no promotion → ld_gnt only; d_gnt the following cycle after ld_req drops.
- Reset mid-read: fetch of 0x0005 issued, clear=1 the next cycle → no f_rvalid for that read; all outputs 0 during clear; normal fetch resumes after clear=0.
- MEM_LAT=3 interleave: alternate d_req read and f_req read → rvalid tags route correctly, with no cross-delivery across 100 randomised accesses checked against a scoreboard.
